y86_seq_ctrl: RTL and testbench

- Stage sequencer for the Y86-64 SEQ processor.
- Steps one instruction through fetch, decode, execute, memory, writeback and PC-update, one stage per cycle.
- Issues per-stage enables, including the execute-stage condition-code write enable, and waits on the data-memory handshake.
- Tracks processor status (AOK/HLT/ADR/INS) and stops the machine on halt or error.

---
 rtl/y86_pkg.sv | 39 +++
 rtl/y86_perf_cnt.sv | 29 ++
 rtl/y86_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_y86_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 instruction codes, status codes and SEQ controller states.
package y86_pkg;

   localparam logic [3:0] HALT   = 4'h0;
   localparam logic [3:0] NOP    = 4'h1;
   localparam logic [3:0] RRMOVQ = 4'h2;
   localparam logic [3:0] IRMOVQ = 4'h3;
   localparam logic [3:0] RMMOVQ = 4'h4;
   localparam logic [3:0] MRMOVQ = 4'h5;
   localparam logic [3:0] OPQ    = 4'h6;
   localparam logic [3:0] JXX    = 4'h7;
   localparam logic [3:0] CALL   = 4'h8;
   localparam logic [3:0] RET    = 4'h9;
   localparam logic [3:0] PUSHQ  = 4'hA;
   localparam logic [3:0] POPQ   = 4'hB;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_MEMORY,
      S_WRITEBACK,
      S_PCUPD,
      S_HALT
   } state_t;

   // Instructions that touch data memory and therefore wait on mem_ready.
   function automatic logic is_mem_icode(input logic [3:0] ic);
      return (ic == RMMOVQ) || (ic == MRMOVQ) || (ic == CALL) ||
             (ic == RET) || (ic == PUSHQ) || (ic == POPQ);
   endfunction

endpackage

// File: rtl/y86_perf_cnt.sv
// rtl/y86_perf_cnt.sv - busy-cycle and retired-instruction counters, wrapping modulo 2^CNT_W.
module y86_perf_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             busy,
   input  logic             retire,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   logic [CNT_W-1:0] r_cycle;
   logic [CNT_W-1:0] r_instr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle <= '0;
         r_instr <= '0;
      end else begin
         if (busy)   r_cycle <= r_cycle + CNT_W'(1);
         if (retire) r_instr <= r_instr + CNT_W'(1);
      end
   end

   assign cycle_count = r_cycle;
   assign instr_count = r_instr;

endmodule

// File: rtl/y86_seq_ctrl.sv
// rtl/y86_seq_ctrl.sv - Y86-64 SEQ stage sequencer with status tracking and memory wait timeout.
// Optional counters enabled by defining Y86_SEQ_PERF_CNT_EN.
module y86_seq_ctrl
   import y86_pkg::*;
#(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [3:0]       icode,
   input  logic             instr_valid,
   input  logic             imem_error,
   input  logic             mem_ready,
   input  logic             dmem_error,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exe_en,
   output logic             mem_en,
   output logic             wb_en,
   output logic             cc_we,
   output logic             pc_we,
   output logic             retire,
   output logic             busy,
   output logic [2:0]       stat,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W = $clog2(WAIT_MAX + 1);

   state_t              r_state;
   logic [3:0]          r_icode;
   logic [WAIT_W-1:0]   r_wait;
   logic [2:0]          r_stat;
   logic                r_fetch_en, r_decode_en, r_exe_en, r_mem_en, r_wb_en;
   logic                r_cc_we, r_pc_we, r_retire, r_busy;

   state_t              w_next;
   logic [2:0]          w_stat;
   logic                w_timeout;

   assign w_timeout = (r_wait == WAIT_W'(WAIT_MAX - 1));

   always_comb begin
      w_next = r_state;
      w_stat = r_stat;
      case (r_state)
         S_IDLE:      if (start) w_next = S_FETCH;
         S_FETCH: begin
            if (imem_error) begin
               w_stat = STAT_ADR;
               w_next = S_HALT;
            end else if (!instr_valid) begin
               w_stat = STAT_INS;
               w_next = S_HALT;
            end else begin
               w_next = S_DECODE;
            end
         end
         S_DECODE:    w_next = S_EXECUTE;
         S_EXECUTE:   w_next = S_MEMORY;
         S_MEMORY: begin
            // mem_ready wins over the timeout on the last permitted cycle.
            if (!is_mem_icode(r_icode)) begin
               w_next = S_WRITEBACK;
            end else if (mem_ready) begin
               if (dmem_error) begin
                  w_stat = STAT_ADR;
                  w_next = S_HALT;
               end else begin
                  w_next = S_WRITEBACK;
               end
            end else if (w_timeout) begin
               w_stat = STAT_ADR;
               w_next = S_HALT;
            end
         end
         S_WRITEBACK: w_next = S_PCUPD;
         S_PCUPD: begin
            if (r_icode == HALT) begin
               w_stat = STAT_HLT;
               w_next = S_HALT;
            end else if (stop) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_FETCH;
            end
         end
         S_HALT:      w_next = S_HALT;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_icode     <= HALT;
         r_wait      <= '0;
         r_stat      <= STAT_AOK;
         r_fetch_en  <= 1'b0;
         r_decode_en <= 1'b0;
         r_exe_en    <= 1'b0;
         r_mem_en    <= 1'b0;
         r_wb_en     <= 1'b0;
         r_cc_we     <= 1'b0;
         r_pc_we     <= 1'b0;
         r_retire    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state <= w_next;
         r_stat  <= w_stat;
         if (r_state == S_FETCH) r_icode <= icode;
         if (r_state == S_MEMORY && w_next == S_MEMORY) r_wait <= r_wait + WAIT_W'(1);
         else                                            r_wait <= '0;
         // Outputs are the decode of the state being entered, so they register with it.
         r_fetch_en  <= (w_next == S_FETCH);
         r_decode_en <= (w_next == S_DECODE);
         r_exe_en    <= (w_next == S_EXECUTE);
         r_mem_en    <= (w_next == S_MEMORY);
         r_wb_en     <= (w_next == S_WRITEBACK);
         r_cc_we     <= (w_next == S_EXECUTE) && (r_icode == OPQ);
         r_pc_we     <= (w_next == S_PCUPD) && (r_icode != HALT);
         r_retire    <= (w_next == S_PCUPD);
         r_busy      <= (w_next != S_IDLE) && (w_next != S_HALT);
      end
   end

   assign fetch_en  = r_fetch_en;
   assign decode_en = r_decode_en;
   assign exe_en    = r_exe_en;
   assign mem_en    = r_mem_en;
   assign wb_en     = r_wb_en;
   assign cc_we     = r_cc_we;
   assign pc_we     = r_pc_we;
   assign retire    = r_retire;
   assign busy      = r_busy;
   assign stat      = r_stat;

`ifdef Y86_SEQ_PERF_CNT_EN
   y86_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
      .clk         (clk),
      .rst         (rst),
      .busy        (r_busy),
      .retire      (r_retire),
      .cycle_count (cycle_count),
      .instr_count (instr_count)
   );
`else
   assign cycle_count = '0;
   assign instr_count = '0;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// tb/tb_y86_seq_ctrl.sv - directed bench for y86_seq_ctrl with a per-instruction stage-occupancy model.
module tb_y86_seq_ctrl;

   localparam int WAIT_MAX = 15;
   localparam int CNT_W    = 32;
   localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
`ifdef Y86_SEQ_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             start = 1'b0, stop = 1'b0;
   logic [3:0]       icode = 4'h0;
   logic             instr_valid = 1'b0, imem_error = 1'b0;
   logic             mem_ready = 1'b0, dmem_error = 1'b0;
   logic             fetch_en, decode_en, exe_en, mem_en, wb_en;
   logic             cc_we, pc_we, retire, busy;
   logic [2:0]       stat;
   logic [CNT_W-1:0] cycle_count, instr_count;

   int               n_checks = 0;
   int               n_fail   = 0;
   logic [2:0]       m_stat;
   int               exp_cyc, exp_ins;

   y86_seq_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .icode(icode),
      .instr_valid(instr_valid), .imem_error(imem_error),
      .mem_ready(mem_ready), .dmem_error(dmem_error),
      .fetch_en(fetch_en), .decode_en(decode_en), .exe_en(exe_en),
      .mem_en(mem_en), .wb_en(wb_en), .cc_we(cc_we), .pc_we(pc_we),
      .retire(retire), .busy(busy), .stat(stat),
      .cycle_count(cycle_count), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] dut_vec();
      return {stat, busy, retire, pc_we, cc_we, wb_en, mem_en, exe_en, decode_en, fetch_en};
   endfunction

   // Stage 0 = idle/halt, 1..5 = fetch..writeback, 6 = PC update.
   function automatic logic [11:0] mk(input int stg, input bit cc, input bit pc,
                                      input bit ret, input logic [2:0] st);
      logic [11:0] v;
      v       = '0;
      v[11:9] = st;
      v[8]    = (stg != 0);
      v[7]    = ret;
      v[6]    = pc;
      v[5]    = cc;
      if (stg >= 1 && stg <= 5) v[stg-1] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare one cycle's outputs against the model, then advance to just after the next edge.
   task automatic cmp(input logic [11:0] v);
      @(negedge clk);
      chk("outputs", {20'h0, dut_vec()}, {20'h0, v});
      chk("cycle_count", cycle_count, PERF ? exp_cyc : 0);
      chk("instr_count", instr_count, PERF ? exp_ins : 0);
      if (v[8]) exp_cyc++;
      if (v[7]) exp_ins++;
   endtask

   task automatic cyc(input logic [11:0] v);
      cmp(v);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      chk("reset_vec", {20'h0, dut_vec()}, 32'h200);
      chk("reset_cnt", cycle_count | instr_count, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_stat  = AOK;
      exp_cyc = 0;
      exp_ins = 0;
   endtask

   task automatic idle_cycle(input bit st);
      start = st;
      cyc(mk(0, 0, 0, 0, m_stat));
      start = 1'b0;
   endtask

   // Steps one instruction from its FETCH cycle; stalls >= WAIT_MAX means mem_ready never comes.
   task automatic run_instr(input logic [3:0] ic, input bit valid, input bit ierr,
                            input int stalls, input bit derr, input bit stop_i);
      bit memop;
      memop = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
              (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
      stop = ~stop_i;
      icode = ic; instr_valid = valid; imem_error = ierr;
      cyc(mk(1, 0, 0, 0, m_stat));
      icode = ~ic; instr_valid = 1'b0; imem_error = 1'b0;
      if (ierr)   begin m_stat = ADR; stop = 1'b0; return; end
      if (!valid) begin m_stat = INS; stop = 1'b0; return; end
      cyc(mk(2, 0, 0, 0, m_stat));
      cyc(mk(3, ic == 4'h6, 0, 0, m_stat));
      if (!memop) begin
         mem_ready = 1'b1; dmem_error = 1'b1;
         cyc(mk(4, 0, 0, 0, m_stat));
      end else begin
         for (int k = 0; k < stalls && k < WAIT_MAX; k++) begin
            mem_ready = 1'b0; dmem_error = 1'b1;
            cyc(mk(4, 0, 0, 0, m_stat));
         end
         if (stalls >= WAIT_MAX) begin
            mem_ready = 1'b0; dmem_error = 1'b0; m_stat = ADR; stop = 1'b0;
            return;
         end
         mem_ready = 1'b1; dmem_error = derr;
         cyc(mk(4, 0, 0, 0, m_stat));
         if (derr) begin
            mem_ready = 1'b0; dmem_error = 1'b0; m_stat = ADR; stop = 1'b0;
            return;
         end
      end
      mem_ready = 1'b0; dmem_error = 1'b0;
      cyc(mk(5, 0, 0, 0, m_stat));
      stop = stop_i;
      cyc(mk(6, 0, ic != 4'h0, 1, m_stat));
      stop = 1'b0;
      if (ic == 4'h0) m_stat = HLT;
   endtask

   initial begin
      #1;
      do_reset();

      // Two OPq back-to-back, then halt.
      idle_cycle(1'b0);
      idle_cycle(1'b1);
      run_instr(4'h6, 1, 0, 0, 0, 0);
      chk("refetch_cycle7", {30'h0, fetch_en, retire}, 32'h2);
      run_instr(4'h6, 1, 0, 0, 0, 0);
      run_instr(4'h0, 1, 0, 0, 0, 0);
      chk("halt_stat", {29'h0, stat}, 32'h2);
      chk("halt_cycles", cycle_count, PERF ? 32'd18 : 32'd0);
      chk("halt_instrs", instr_count, PERF ? 32'd3 : 32'd0);
      stop = 1'b1;
      idle_cycle(1'b1);
      idle_cycle(1'b1);
      stop = 1'b0;

      // Memory instructions: no stall, non-memory with noisy handshake, 3 stalls, WAIT_MAX-1 stalls.
      do_reset();
      idle_cycle(1'b1);
      run_instr(4'h4, 1, 0, 0, 0, 0);
      run_instr(4'h7, 1, 0, 0, 0, 0);
      run_instr(4'hB, 1, 0, WAIT_MAX - 1, 0, 0);
      run_instr(4'h5, 1, 0, 3, 0, 1);
      chk("mem_ok_stat", {29'h0, stat}, 32'h1);
      idle_cycle(1'b0);

      // Memory never ready: address error after WAIT_MAX stalls.
      idle_cycle(1'b1);
      run_instr(4'hA, 1, 0, WAIT_MAX + 5, 0, 0);
      chk("timeout_stat", {29'h0, stat}, 32'h3);
      chk("timeout_busy", {31'h0, busy}, 32'h0);
      idle_cycle(1'b1);

      // Illegal instruction, then start is ignored in HALT.
      do_reset();
      idle_cycle(1'b1);
      run_instr(4'h3, 0, 0, 0, 0, 0);
      chk("ins_stat", {29'h0, stat}, 32'h4);
      idle_cycle(1'b1);
      idle_cycle(1'b1);
      do_reset();
      idle_cycle(1'b0);

      // imem_error beats instr_valid.
      idle_cycle(1'b1);
      run_instr(4'h2, 1, 1, 0, 0, 0);
      idle_cycle(1'b1);

      // Data memory error suppresses writeback.
      do_reset();
      idle_cycle(1'b1);
      run_instr(4'h8, 1, 0, 2, 1, 0);
      idle_cycle(1'b0);

      // Reset in EXECUTE of an OPq abandons the instruction.
      do_reset();
      idle_cycle(1'b1);
      icode = 4'h6; instr_valid = 1'b1;
      cyc(mk(1, 0, 0, 0, m_stat));
      icode = 4'h0;
      cyc(mk(2, 0, 0, 0, m_stat));
      cmp(mk(3, 1, 0, 0, m_stat));
      #1;
      do_reset();
      for (int i = 0; i < 6; i++) idle_cycle(1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
